// File: rtl/ex_hazard_ctrl_if.sv
// EX-stage hazard control bundle: EX instruction decode fields and WB load status in,
// forwarding-mux selects and pipeline stall/flush controls out.
interface ex_hazard_ctrl_if;
    logic       ex_valid;
    logic [4:0] ex_rs1;
    logic [4:0] ex_rs2;
    logic       ex_uses_rs1;
    logic       ex_uses_rs2;
    logic       ex_a_pc;
    logic       ex_b_imm;
    logic [4:0] ex_rd;
    logic       ex_regwen;
    logic       ex_is_load;
    logic       ex_br_taken;
    logic       wb_load_ready;
    logic [1:0] asel;
    logic [1:0] bsel;
    logic       stall;
    logic       flush;
    logic       load_timeout;

    modport master (
        output ex_valid, ex_rs1, ex_rs2, ex_uses_rs1, ex_uses_rs2, ex_a_pc, ex_b_imm,
        output ex_rd, ex_regwen, ex_is_load, ex_br_taken, wb_load_ready,
        input  asel, bsel, stall, flush, load_timeout
    );

    modport slave (
        input  ex_valid, ex_rs1, ex_rs2, ex_uses_rs1, ex_uses_rs2, ex_a_pc, ex_b_imm,
        input  ex_rd, ex_regwen, ex_is_load, ex_br_taken, wb_load_ready,
        output asel, bsel, stall, flush, load_timeout
    );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: one-entry WB scoreboard driving operand forwarding,
// load-use stall while dmem is pending, and post-branch flush of the younger instruction.
module ex_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned LOAD_TIMEOUT = 64
) (
    input logic             clk,
    input logic             rst,
    ex_hazard_ctrl_if.slave bus
);
    localparam int unsigned FlushCntW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int unsigned WaitCntW  = $clog2(LOAD_TIMEOUT);
    localparam logic [FlushCntW-1:0] FlushInit = FlushCntW'(FLUSH_CYCLES - 1);
    localparam logic [WaitCntW-1:0]  WaitMax   = WaitCntW'(LOAD_TIMEOUT - 1);

    typedef enum logic [1:0] {StRun, StLoadWait, StFlush} state_e;

    state_e                state_q, state_d;
    logic [FlushCntW-1:0]  flush_cnt_q, flush_cnt_d;
    logic [WaitCntW-1:0]   wait_cnt_q, wait_cnt_d;
    logic                  timeout_q;

    logic                  wb_valid_q;
    logic [4:0]            wb_rd_q;
    logic                  wb_regwen_q;
    logic                  wb_is_load_q;

    logic                  stall;
    logic                  fwd1;
    logic                  fwd2;
    logic                  flush_now;
    logic                  flush;
    logic                  timeout_hit;

    always_comb begin
        stall = wb_valid_q & wb_is_load_q & ~bus.wb_load_ready;
        fwd1  = bus.ex_valid & bus.ex_uses_rs1 & wb_valid_q & wb_regwen_q &
                (wb_rd_q != 5'd0) & (wb_rd_q == bus.ex_rs1);
        fwd2  = bus.ex_valid & bus.ex_uses_rs2 & wb_valid_q & wb_regwen_q &
                (wb_rd_q != 5'd0) & (wb_rd_q == bus.ex_rs2);
        // A branch held in EX by a stall is taken on the first cycle the stall releases.
        flush_now   = ~rst & (state_q != StFlush) & bus.ex_valid & bus.ex_br_taken & ~stall;
        flush       = ~rst & ((state_q == StFlush) | flush_now);
        timeout_hit = (state_q == StLoadWait) & (wait_cnt_q == WaitMax);
    end

    assign bus.asel         = rst ? 2'b00 : {fwd1, bus.ex_valid & bus.ex_a_pc};
    assign bus.bsel         = rst ? 2'b00 : {fwd2, bus.ex_valid & bus.ex_b_imm};
    assign bus.stall        = stall;
    assign bus.flush        = flush;
    assign bus.load_timeout = timeout_q | timeout_hit;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        unique case (state_q)
            StRun: begin
                if (stall) begin
                    state_d    = StLoadWait;
                    wait_cnt_d = '0;
                end else if (flush_now) begin
                    state_d     = StFlush;
                    flush_cnt_d = FlushInit;
                end
            end
            StLoadWait: begin
                if (!stall) begin
                    wait_cnt_d = '0;
                    if (flush_now) begin
                        state_d     = StFlush;
                        flush_cnt_d = FlushInit;
                    end else begin
                        state_d = StRun;
                    end
                end else if (wait_cnt_q != WaitMax) begin
                    // Saturate so the timeout compare cannot wrap around.
                    wait_cnt_d = wait_cnt_q + WaitCntW'(1);
                end
            end
            StFlush: begin
                if (!stall) begin
                    if (flush_cnt_q == '0) begin
                        state_d = StRun;
                    end else begin
                        flush_cnt_d = flush_cnt_q - FlushCntW'(1);
                    end
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_q | timeout_hit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= 5'd0;
            wb_regwen_q  <= 1'b0;
            wb_is_load_q <= 1'b0;
        end else if (!stall) begin
            wb_valid_q   <= bus.ex_valid & ~flush;
            wb_rd_q      <= bus.ex_rd;
            wb_regwen_q  <= bus.ex_regwen;
            wb_is_load_q <= bus.ex_is_load;
        end
    end
endmodule
